// File: rtl/mul_acc.sv
// mul_acc: signed 16x16 multiply-accumulate with grouped, saturating sums.
// Two-stage pipeline (product register, accumulator/output register) under valid/ready flow control.
module mul_acc #(
   parameter int ACC_W = 40
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [15:0]      a,
   input  logic signed [15:0]      b,
   input  logic                    first,
   input  logic                    last,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [ACC_W-1:0] acc_out,
   output logic                    ovf
);

   // Radix-4 Booth recoding of y; the eight partial products are reduced by one adder tree.
   function automatic logic signed [31:0] booth_mul(input logic signed [15:0] x,
                                                    input logic signed [15:0] y);
      logic signed [31:0] xe;
      logic signed [31:0] pp;
      logic signed [31:0] sum;
      logic        [16:0] yb;
      logic        [2:0]  grp;
      xe  = {{16{x[15]}}, x};
      yb  = {y, 1'b0};
      sum = 32'sd0;
      for (int i = 32'sd0; i < 32'sd8; i++) begin
         grp = yb[i*32'sd2 +: 3];
         case (grp)
            3'b001, 3'b010: pp = xe;
            3'b011:         pp = xe <<< 1;
            3'b100:         pp = -(xe <<< 1);
            3'b101, 3'b110: pp = -xe;
            default:        pp = 32'sd0;
         endcase
         sum = sum + (pp <<< (i*32'sd2));
      end
      return sum;
   endfunction

   // Returns {overflow, clamped sum}; the extra top bit exposes signed overflow.
   function automatic logic [ACC_W:0] sat_add(input logic signed [ACC_W-1:0] x,
                                              input logic signed [31:0]      p);
      logic [ACC_W:0] s;
      s = {x[ACC_W-1], x} + {{(ACC_W-31){p[31]}}, p};
      if (s[ACC_W] != s[ACC_W-1]) begin
         if (s[ACC_W]) begin
            return {1'b1, 1'b1, {(ACC_W-1){1'b0}}};
         end else begin
            return {1'b1, 1'b0, {(ACC_W-1){1'b1}}};
         end
      end else begin
         return {1'b0, s[ACC_W-1:0]};
      end
   endfunction

   logic                    stall_s;
   logic signed [31:0]      prod_s;
   logic        [ACC_W:0]   sum_s;
   logic signed [ACC_W-1:0] acc_next_s;
   logic                    ovf_next_s;

   logic                    s1_valid_r;
   logic signed [31:0]      s1_prod_r;
   logic                    s1_first_r;
   logic                    s1_last_r;
   logic signed [ACC_W-1:0] acc_r;
   logic                    acc_ovf_r;

   assign stall_s  = out_valid && !out_ready;
   assign in_ready = !stall_s && !rst;
   assign prod_s   = booth_mul(a, b);

   // Next accumulator value: a first beat restarts the group, others add with saturation.
   always_comb begin
      sum_s = sat_add(acc_r, s1_prod_r);
      if (s1_first_r) begin
         acc_next_s = {{(ACC_W-32){s1_prod_r[31]}}, s1_prod_r};
         ovf_next_s = 1'b0;
      end else begin
         acc_next_s = sum_s[ACC_W-1:0];
         ovf_next_s = acc_ovf_r | sum_s[ACC_W];
      end
   end

   // Stage 1: capture the accepted beat, or a bubble, whenever the output is not stalled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_r <= 1'b0;
         s1_prod_r  <= 32'sd0;
         s1_first_r <= 1'b0;
         s1_last_r  <= 1'b0;
      end else if (!stall_s) begin
         s1_valid_r <= in_valid && in_ready;
         s1_prod_r  <= prod_s;
         s1_first_r <= first;
         s1_last_r  <= last;
      end
   end

   // Stage 2: accumulator, sticky group overflow and the registered result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_r     <= {ACC_W{1'b0}};
         acc_ovf_r <= 1'b0;
         acc_out   <= {ACC_W{1'b0}};
         ovf       <= 1'b0;
         out_valid <= 1'b0;
      end else if (!stall_s) begin
         if (s1_valid_r) begin
            acc_r     <= acc_next_s;
            acc_ovf_r <= ovf_next_s;
         end
         if (s1_valid_r && s1_last_r) begin
            acc_out   <= acc_next_s;
            ovf       <= ovf_next_s;
            out_valid <= 1'b1;
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mul_acc.sv
// Self-checking bench for mul_acc: directed scenarios plus randomized traffic
// against an integer-arithmetic group-sum model.
`timescale 1ns/1ps
module tb_mul_acc;
   localparam int     ACC_W = 40;
   localparam longint MAXV  = (64'sd1 <<< (ACC_W-1)) - 64'sd1;
   localparam longint MINV  = -(64'sd1 <<< (ACC_W-1));

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    in_valid;
   logic                    in_ready;
   logic signed [15:0]      a;
   logic signed [15:0]      b;
   logic                    first;
   logic                    last;
   logic                    out_valid;
   logic                    out_ready;
   logic signed [ACC_W-1:0] acc_out;
   logic                    ovf;

   int errors = 0;
   int checks = 0;

   longint exp_v[$];
   bit     exp_o[$];
   longint obs_v[$];
   bit     obs_o[$];
   longint macc;
   bit     movf;

   mul_acc #(.ACC_W(ACC_W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .first(first), .last(last),
      .out_valid(out_valid), .out_ready(out_ready), .acc_out(acc_out), .ovf(ovf)
   );

   always #5 clk = ~clk;

   // Reference model: group sums with plain integer arithmetic and clamping; also records delivered results.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         macc = 0;
         movf = 1'b0;
         exp_v.delete(); exp_o.delete(); obs_v.delete(); obs_o.delete();
      end else begin
         if (out_valid && out_ready) begin
            obs_v.push_back(longint'(acc_out));
            obs_o.push_back(ovf);
         end
         if (in_valid && in_ready) begin
            longint p;
            longint s;
            p = longint'(a) * longint'(b);
            if (first) begin
               macc = p;
               movf = 1'b0;
            end else begin
               s = macc + p;
               if (s > MAXV) begin
                  macc = MAXV; movf = 1'b1;
               end else if (s < MINV) begin
                  macc = MINV; movf = 1'b1;
               end else begin
                  macc = s;
               end
            end
            if (last) begin
               exp_v.push_back(macc);
               exp_o.push_back(movf);
            end
         end
      end
   end

   function automatic logic signed [15:0] pick();
      int unsigned r;
      r = $urandom_range(0, 7);
      if (r == 0) return 16'sh8000;
      if (r == 1) return 16'sh7fff;
      return 16'($urandom);
   endfunction

   // Present one beat (called at a falling edge) and hold it until accepted.
   task automatic send(input logic signed [15:0] va, input logic signed [15:0] vb,
                       input logic vf, input logic vl);
      int n;
      in_valid = 1'b1; a = va; b = vb; first = vf; last = vl;
      #1;
      n = 0;
      while (in_ready !== 1'b1 && n < 200) begin
         @(negedge clk); #1; n++;
      end
      if (in_ready !== 1'b1) begin
         errors++; checks++;
         $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      a = 16'sd0; b = 16'sd0; first = 1'b0; last = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
      checks++; if (acc_out !== '0) begin errors++; $display("FAIL reset_acc_out: got %0d required 0", acc_out); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b required 0", ovf); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b required 0", in_ready); end
      rst = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b required 1", in_ready); end
      @(negedge clk);
   endtask

   task automatic test_single();
      out_ready = 1'b1;
      send(16'sd3, -16'sd5, 1'b1, 1'b1);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_early: out_valid=%b required 0", out_valid); end
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b required 1", out_valid); end
      checks++; if (longint'(acc_out) !== -64'sd15) begin errors++; $display("FAIL single_acc: got %0d required -15", acc_out); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL single_ovf: got %b required 0", ovf); end
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_consumed: out_valid=%b required 0", out_valid); end
   endtask

   task automatic test_three_beat();
      out_ready = 1'b1;
      send(16'sd100, 16'sd200, 1'b1, 1'b0);
      send(-16'sd7, 16'sd9, 1'b0, 1'b0);
      send(16'sd32767, 16'sd32767, 1'b0, 1'b1);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL three_early: out_valid=%b required 0", out_valid); end
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL three_valid: got %b required 1", out_valid); end
      checks++; if (longint'(acc_out) !== 64'sd1073696226) begin errors++; $display("FAIL three_acc: got %0d required 1073696226", acc_out); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL three_ovf: got %b required 0", ovf); end
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL three_one_cycle: out_valid=%b required 0", out_valid); end
   endtask

   task automatic test_saturation();
      out_ready = 1'b1;
      for (int i = 0; i < 600; i++) send(16'sd32767, 16'sd32767, i == 0, i == 599);
      @(negedge clk);
      checks++; if (longint'(acc_out) !== MAXV || out_valid !== 1'b1) begin errors++; $display("FAIL sat_acc: got %0d valid=%b required %0d", acc_out, out_valid, MAXV); end
      checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL sat_ovf: got %b required 1", ovf); end
      @(negedge clk);
      send(16'sd2, 16'sd2, 1'b1, 1'b1);
      @(negedge clk);
      checks++; if (longint'(acc_out) !== 64'sd4) begin errors++; $display("FAIL sat_next_acc: got %0d required 4", acc_out); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL sat_next_ovf: got %b required 0", ovf); end
   endtask

   task automatic test_corner();
      out_ready = 1'b1;
      send(16'sh8000, 16'sh8000, 1'b1, 1'b1);
      @(negedge clk);
      checks++; if (longint'(acc_out) !== 64'sd1073741824) begin errors++; $display("FAIL corner_min_min: got %0d required 1073741824", acc_out); end
      send(16'sh8000, 16'sh7fff, 1'b1, 1'b1);
      @(negedge clk);
      checks++; if (longint'(acc_out) !== -64'sd1073709056) begin errors++; $display("FAIL corner_min_max: got %0d required -1073709056", acc_out); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b1;
      send(16'sd11, 16'sd13, 1'b1, 1'b0);
      send(-16'sd17, 16'sd19, 1'b0, 1'b0);
      rst = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b required 0", out_valid); end
      checks++; if (acc_out !== '0) begin errors++; $display("FAIL midrst_acc_out: got %0d required 0", acc_out); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL midrst_ovf: got %b required 0", ovf); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL midrst_in_ready: got %b required 0", in_ready); end
      @(negedge clk);
      rst = 1'b0;
      send(16'sd4, 16'sd5, 1'b0, 1'b1);
      @(negedge clk);
      checks++; if (longint'(acc_out) !== 64'sd20) begin errors++; $display("FAIL after_reset_accumulate: got %0d required 20", acc_out); end
      send(16'sd5, 16'sd5, 1'b1, 1'b1);
      @(negedge clk);
      checks++; if (longint'(acc_out) !== 64'sd25) begin errors++; $display("FAIL after_reset_group: got %0d required 25", acc_out); end
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      logic signed [15:0] va[3];
      logic signed [15:0] vb[3];
      longint g1;
      longint g2;
      int n;
      for (int i = 0; i < 3; i++) begin va[i] = pick(); vb[i] = pick(); end
      g1 = longint'(va[0]) * longint'(vb[0]);
      g2 = longint'(va[1]) * longint'(vb[1]) + longint'(va[2]) * longint'(vb[2]);
      exp_v.delete(); exp_o.delete(); obs_v.delete(); obs_o.delete();
      out_ready = 1'b0;
      send(va[0], vb[0], 1'b1, 1'b1);
      send(va[1], vb[1], 1'b1, 1'b0);
      in_valid = 1'b1; a = va[2]; b = vb[2]; first = 1'b0; last = 1'b1;
      repeat (4) begin
         #1;
         checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_stall: in_ready=%b out_valid=%b required 0/1", in_ready, out_valid); end
         checks++; if (longint'(acc_out) !== g1 || ovf !== 1'b0) begin errors++; $display("FAIL bp_hold: got %0d ovf=%b required %0d ovf=0", acc_out, ovf, g1); end
         @(negedge clk);
      end
      out_ready = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release: in_ready=%b required 1", in_ready); end
      @(negedge clk);
      in_valid = 1'b0;
      n = 0;
      while (obs_v.size() < 2 && n < 20) begin @(negedge clk); n++; end
      checks++;
      if (obs_v.size() != 2) begin
         errors++; $display("FAIL bp_count: got %0d results required 2", obs_v.size());
      end else begin
         checks++; if (obs_v[0] !== g1) begin errors++; $display("FAIL bp_first: got %0d required %0d", obs_v[0], g1); end
         checks++; if (obs_v[1] !== g2 || obs_o[1] !== 1'b0) begin errors++; $display("FAIL bp_second: got %0d required %0d", obs_v[1], g2); end
      end
      @(negedge clk);
   endtask

   task automatic test_random();
      int  grp_left;
      bit  have;
      bit  acc_pend;
      int  n;
      grp_left = 0; have = 1'b0; acc_pend = 1'b0;
      exp_v.delete(); exp_o.delete(); obs_v.delete(); obs_o.delete();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (acc_pend) begin
            have = 1'b0;
            grp_left--;
         end
         out_ready = ($urandom_range(0, 3) != 0);
         if (!have && $urandom_range(0, 3) != 0) begin
            if (grp_left == 0) begin
               grp_left = $urandom_range(1, 6);
               first = ($urandom_range(0, 7) != 0);
            end else begin
               first = 1'b0;
            end
            last = (grp_left == 1);
            a = pick(); b = pick();
            have = 1'b1;
         end
         in_valid = have;
         #1;
         acc_pend = in_valid && in_ready;
         @(negedge clk);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      n = 0;
      while ((out_valid || obs_v.size() != exp_v.size()) && n < 100) begin @(negedge clk); n++; end
      repeat (3) @(negedge clk);
      checks++; if (exp_v.size() == 0 || obs_v.size() != exp_v.size()) begin errors++; $display("FAIL rand_count: got %0d results required %0d (nonzero)", obs_v.size(), exp_v.size()); end
      for (int i = 0; i < exp_v.size() && i < obs_v.size(); i++) begin
         checks++;
         if (obs_v[i] !== exp_v[i] || obs_o[i] !== exp_o[i]) begin
            errors++;
            $display("FAIL rand_result[%0d]: got %0d ovf=%b required %0d ovf=%b", i, obs_v[i], obs_o[i], exp_v[i], exp_o[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_three_beat();
      test_saturation();
      test_corner();
      test_reset_mid();
      test_backpressure();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
